data_sram_bridge: RTL and testbench
===================================

Name: data_sram_bridge

Overview:
Sits directly downstream of the MEM-stage store/load formatting logic and upstream of the load-result formatting logic. Converts one pipeline memory access (byte enables, address, aligned write data) into a transaction on the SRAM-like data bus (req/addr_ok/data_ok). It stalls the pipeline until the transaction completes and returns the raw 32-bit word for load formatting. At most one transaction is outstanding; a cancelled access is drained silently.

Parameters:
FORCE_WORD_ALIGN, 1, when 1 and data_size==2, data_addr[1:0] is driven as 2'b00; when 0, addr passes unmodified
RESET_RDATA, 32'h0, reset/idle value of mem_rdata

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  MEM stage holds a valid instruction
mem_ren  in  1  instruction is a load (any width/partial)
mem_wen  in  4  byte write enables, already gated by valid; non-zero means store
mem_addr  in  32  effective address
mem_wdata  in  32  byte-lane-aligned store data
mem_cancel  in  1  flush/exception: abandon current access
mem_allowout  in  1  downstream stage accepts MEM result this cycle
mem_stall  out  1  MEM stage must hold
mem_rdata  out  32  raw load word to load formatting
mem_done  out  1  access of current MEM instruction complete (level)
data_req  out  1  bus request
data_wr  out  1  1 = write
data_size  out  2  0 byte, 1 half, 2 word
data_wstrb  out  4  byte strobes (copy of mem_wen on writes, 0 on reads)
data_addr  out  32  bus address
data_wdata  out  32  bus write data
data_addr_ok  in  1  request accepted
data_rdata  in  32  read data
data_data_ok  in  1  response valid

Behaviour:
- access = mem_valid & (mem_ren | |mem_wen) & ~mem_cancel; mem_ren and nonzero mem_wen never both high (protocol error otherwise; writes win).
- data_size from strobe/load popcount: 1 byte ->0, 2 ->1, 3 or 4 ->2; loads supply size via mem_wen-equivalent rule: load size is 2 unless byte/half decoded upstream — loads always issue size 2 (full word, formatting done downstream).
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: access -> REQ (request registered, data_req asserted next cycle). Otherwise stay.
- REQ: data_req=1, all data_* held stable from registered copy. data_addr_ok -> WAIT. mem_cancel while in REQ and no addr_ok -> IDLE (request withdrawn); cancel with addr_ok same cycle -> DRAIN.
- WAIT: data_data_ok -> capture data_rdata into mem_rdata (reads only), go DONE. mem_cancel -> DRAIN; cancel and data_data_ok same cycle -> IDLE, data discarded.
- DONE: mem_done=1, mem_stall=0. mem_allowout -> IDLE; if a new access is presented the same cycle, go REQ directly (back-to-back, one idle bubble max avoided). mem_cancel in DONE -> IDLE.
- DRAIN: data_req=0, mem_stall=0, mem_done=0; wait data_data_ok, discard, -> IDLE. New access presented during DRAIN is not issued until IDLE (mem_stall=1 for that new access).
- mem_stall = access & state!=DONE, plus pending new access during DRAIN.
- data_addr_ok and data_data_ok in the same cycle while in REQ: treated as addr_ok then data_ok -> DONE directly.
- mem_rdata holds last captured value until next capture; writes do not update it.
- Reset (async, resetn=0): state IDLE, data_req=0, data_wr=0, data_size=0, data_wstrb=0, data_addr=0, data_wdata=0, mem_rdata=RESET_RDATA, mem_done=0, mem_stall=0. Reset mid-transaction abandons it; no drain.
- Minimum latency: access at cycle 0, req at 1, addr_ok+data_ok at 1 -> mem_done at 2.

Decomposition:
- Shared defines header: FSM state encodings (3-bit), BUS_SIZE_BYTE/HALF/WORD constants.
- One sub-module natural: bus_size_decode (wen/ren -> size, strobe, aligned addr), combinational.

Test Plan:
- Load word addr 0x1000, slave addr_ok cycle 1, data_ok cycle 3 with 0xDEADBEEF -> data_size=2, wr=0, stall cycles 0-3, mem_rdata=0xDEADBEEF, mem_done at cycle 4.
- Store byte wen=4'b0100 addr 0x2002 wdata 0x00AB0000 -> data_wr=1, size=0, wstrb=0100, addr 0x2002; swl wen=0111 addr 0x2002 -> size=2, addr 0x2000.
- Cancel in WAIT, data_ok two cycles later with 0x12345678 -> mem_stall drops at cancel, mem_rdata unchanged, FSM IDLE after data_ok.
- Cancel same cycle as addr_ok in REQ -> DRAIN; next load presented during DRAIN issues only after data_ok drained.
- Back-to-back loads with mem_allowout in DONE -> second data_req asserted the cycle after DONE, no extra IDLE cycle.
- resetn low during WAIT -> all outputs reset values immediately, data_req=0.

Source files
------------

// File: rtl/data_sram_bridge_pkg.sv
// Shared types and constants for the MEM-stage to SRAM-like data bus bridge.
// Holds the FSM state encoding, the bus size codes and a byte-strobe counter.
package data_sram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } bridge_state_e;

  localparam logic [1:0] BUS_SIZE_BYTE = 2'd0;
  localparam logic [1:0] BUS_SIZE_HALF = 2'd1;
  localparam logic [1:0] BUS_SIZE_WORD = 2'd2;

  function automatic logic [2:0] strobe_count(input logic [3:0] s);
    return {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
  endfunction

endpackage

// File: rtl/data_sram_bridge_size_decode.sv
// Combinational decode of a MEM access into bus size, strobes and address.
// Loads always go out as full words; stores are sized by strobe count.
module data_sram_bridge_size_decode
  import data_sram_bridge_pkg::*;
#(
  parameter bit FORCE_WORD_ALIGN = 1'b1
) (
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  output logic        is_write,
  output logic [1:0]  size,
  output logic [3:0]  strobe,
  output logic [31:0] addr
);

  logic [2:0] cnt;

  always_comb begin
    cnt      = strobe_count(mem_wen);
    is_write = |mem_wen;
    strobe   = is_write ? mem_wen : 4'b0000;
    size     = BUS_SIZE_WORD;
    if (is_write) begin
      case (cnt)
        3'd1:    size = BUS_SIZE_BYTE;
        3'd2:    size = BUS_SIZE_HALF;
        default: size = BUS_SIZE_WORD;
      endcase
    end
    addr = mem_addr;
    // Unaligned word stores (swl/swr style) are issued at the containing word.
    if (FORCE_WORD_ALIGN && (size == BUS_SIZE_WORD)) addr[1:0] = 2'b00;
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Bridges one MEM-stage access onto the req/addr_ok/data_ok data bus,
// stalling the pipeline until done and silently draining cancelled accesses.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter bit          FORCE_WORD_ALIGN = 1'b1,
  parameter logic [31:0] RESET_RDATA      = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_ren,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_cancel,
  input  logic        mem_allowout,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  bridge_state_e state_q, state_d;
  logic          access;
  logic          issue;
  logic          capture;
  logic          dec_wr;
  logic [1:0]    dec_size;
  logic [3:0]    dec_strobe;
  logic [31:0]   dec_addr;

  assign access = mem_valid & (mem_ren | (|mem_wen)) & ~mem_cancel;

  data_sram_bridge_size_decode #(
    .FORCE_WORD_ALIGN(FORCE_WORD_ALIGN)
  ) u_size_decode (
    .mem_wen (mem_wen),
    .mem_addr(mem_addr),
    .is_write(dec_wr),
    .size    (dec_size),
    .strobe  (dec_strobe),
    .addr    (dec_addr)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (data_addr_ok) begin
          if (mem_cancel)        state_d = data_data_ok ? ST_IDLE : ST_DRAIN;
          else if (data_data_ok) begin
            state_d = ST_DONE;
            capture = ~data_wr;
          end else               state_d = ST_WAIT;
        end else if (mem_cancel) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_cancel)        state_d = data_data_ok ? ST_IDLE : ST_DRAIN;
        else if (data_data_ok) begin
          state_d = ST_DONE;
          capture = ~data_wr;
        end
      end
      ST_DONE: begin
        // A fresh access alongside allowout goes straight back to REQ.
        if (mem_cancel)        state_d = ST_IDLE;
        else if (mem_allowout) state_d = access ? ST_REQ : ST_IDLE;
      end
      ST_DRAIN: begin
        if (data_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue = (state_d == ST_REQ) && (state_q != ST_REQ);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      data_wr    <= 1'b0;
      data_size  <= BUS_SIZE_BYTE;
      data_wstrb <= 4'b0000;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
      mem_rdata  <= RESET_RDATA;
    end else begin
      state_q <= state_d;
      if (issue) begin
        data_wr    <= dec_wr;
        data_size  <= dec_size;
        data_wstrb <= dec_strobe;
        data_addr  <= dec_addr;
        data_wdata <= mem_wdata;
      end
      if (capture) mem_rdata <= data_rdata;
    end
  end

  assign data_req  = (state_q == ST_REQ);
  assign mem_done  = (state_q == ST_DONE);
  assign mem_stall = resetn & access & (state_q != ST_DONE);

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scenario bench for data_sram_bridge: scripted protocol cases plus randomized
// loads/stores checked against a transaction-level expectation model.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_ren, mem_cancel, mem_allowout;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_stall, mem_done;
  logic [31:0] mem_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  data_sram_bridge dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cancel(mem_cancel),
    .mem_allowout(mem_allowout), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 4'b0; mem_addr = 32'h0;
    mem_wdata = 32'h0; mem_cancel = 1'b0; mem_allowout = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  task automatic present(input logic ren, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wd);
    mem_valid = 1'b1; mem_ren = ren; mem_wen = wen; mem_addr = addr;
    mem_wdata = wd; mem_cancel = 1'b0; mem_allowout = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive_idle();
    data_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    mem_valid = 1'b1; mem_ren = 1'b1;
    #1;
    n_chk++;
    if ({data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata} !== 72'h0)
      $display("FAIL reset_bus: got req=%b wr=%b size=%0d strb=%b addr=%h wdata=%h, exp all zero",
               data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata);
    else n_pass++;
    n_chk++;
    if ({mem_stall, mem_done, mem_rdata} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL reset_mem: got stall=%b done=%b rdata=%h, exp 0 0 00000000", mem_stall, mem_done, mem_rdata);
    else n_pass++;
    drive_idle();
    next();
    resetn = 1'b1;
    next();
  endtask

  task automatic test_load_word();
    present(1'b1, 4'b0, 32'h1000, 32'h0);
    @(negedge clk);
    n_chk++;
    if ({mem_stall, data_req} !== 2'b10) $display("FAIL lw_c0: got stall=%b req=%b, exp 1 0", mem_stall, data_req);
    else n_pass++;
    next();
    data_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({data_req, data_wr, data_size, data_wstrb, data_addr, mem_stall} !== {1'b1, 1'b0, 2'd2, 4'b0, 32'h1000, 1'b1})
      $display("FAIL lw_req: got req=%b wr=%b size=%0d strb=%b addr=%h stall=%b, exp 1 0 2 0000 00001000 1",
               data_req, data_wr, data_size, data_wstrb, data_addr, mem_stall);
    else n_pass++;
    next();
    data_addr_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({data_req, mem_stall, mem_done} !== 3'b010) $display("FAIL lw_wait: got req=%b stall=%b done=%b, exp 0 1 0", data_req, mem_stall, mem_done);
    else n_pass++;
    next();
    data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_chk++;
    if ({mem_stall, mem_done} !== 2'b10) $display("FAIL lw_c3: got stall=%b done=%b, exp 1 0", mem_stall, mem_done);
    else n_pass++;
    next();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    exp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_chk++;
    if ({mem_done, mem_stall, mem_rdata} !== {1'b1, 1'b0, exp_rdata})
      $display("FAIL lw_done: got done=%b stall=%b rdata=%h, exp 1 0 %h", mem_done, mem_stall, mem_rdata, exp_rdata);
    else n_pass++;
    mem_allowout = 1'b1; mem_valid = 1'b0; mem_ren = 1'b0;
    next();
    drive_idle();
    @(negedge clk);
    n_chk++;
    if ({mem_done, data_req} !== 2'b00) $display("FAIL lw_idle: got done=%b req=%b, exp 0 0", mem_done, data_req);
    else n_pass++;
  endtask

  task automatic test_store();
    logic [3:0]  wen [3];
    logic [31:0] addr[3];
    logic [31:0] wd  [3];
    logic [1:0]  es  [3];
    logic [31:0] ea  [3];
    wen[0] = 4'b0100; addr[0] = 32'h2002; wd[0] = 32'h00AB0000; es[0] = 2'd0; ea[0] = 32'h2002;
    wen[1] = 4'b0111; addr[1] = 32'h2002; wd[1] = 32'h00CDEF12; es[1] = 2'd2; ea[1] = 32'h2000;
    wen[2] = 4'b1100; addr[2] = 32'h2006; wd[2] = 32'h55660000; es[2] = 2'd1; ea[2] = 32'h2006;
    for (int i = 0; i < 3; i++) begin
      present(1'b0, wen[i], addr[i], wd[i]);
      next();
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF0000;
      @(negedge clk);
      n_chk++;
      if ({data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata} !== {1'b1, 1'b1, es[i], wen[i], ea[i], wd[i]})
        $display("FAIL st%0d_bus: got req=%b wr=%b size=%0d strb=%b addr=%h wdata=%h, exp 1 1 %0d %b %h %h",
                 i, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, es[i], wen[i], ea[i], wd[i]);
      else n_pass++;
      next();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({mem_done, mem_rdata} !== {1'b1, exp_rdata})
        $display("FAIL st%0d_done: got done=%b rdata=%h, exp 1 %h", i, mem_done, mem_rdata, exp_rdata);
      else n_pass++;
      mem_allowout = 1'b1; mem_valid = 1'b0; mem_wen = 4'b0;
      next();
      drive_idle();
    end
  endtask

  task automatic test_cancel_wait();
    present(1'b1, 4'b0, 32'h3000, 32'h0);
    next();
    data_addr_ok = 1'b1;
    next();
    data_addr_ok = 1'b0;
    mem_cancel = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mem_stall !== 1'b0) $display("FAIL cw_stall: got %b, exp 0", mem_stall);
    else n_pass++;
    next();
    mem_cancel = 1'b0; mem_valid = 1'b0; mem_ren = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({data_req, mem_stall, mem_done} !== 3'b000) $display("FAIL cw_drain: got req=%b stall=%b done=%b, exp 0 0 0", data_req, mem_stall, mem_done);
    else n_pass++;
    next();
    data_data_ok = 1'b1; data_rdata = 32'h12345678;
    @(negedge clk);
    n_chk++;
    if ({mem_done, mem_stall} !== 2'b00) $display("FAIL cw_dok: got done=%b stall=%b, exp 0 0", mem_done, mem_stall);
    else n_pass++;
    next();
    data_data_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_done, data_req, mem_rdata} !== {1'b0, 1'b0, exp_rdata})
      $display("FAIL cw_rdata: got done=%b req=%b rdata=%h, exp 0 0 %h", mem_done, data_req, mem_rdata, exp_rdata);
    else n_pass++;
    present(1'b1, 4'b0, 32'h3100, 32'h0);
    next();
    @(negedge clk);
    n_chk++;
    if ({data_req, data_addr} !== {1'b1, 32'h3100}) $display("FAIL cw_idle: got req=%b addr=%h, exp 1 00003100", data_req, data_addr);
    else n_pass++;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BADCAFE;
    next();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    exp_rdata = 32'h0BADCAFE;
    @(negedge clk);
    n_chk++;
    if ({mem_done, mem_rdata} !== {1'b1, exp_rdata}) $display("FAIL cw_next: got done=%b rdata=%h, exp 1 %h", mem_done, mem_rdata, exp_rdata);
    else n_pass++;
    mem_allowout = 1'b1; mem_valid = 1'b0; mem_ren = 1'b0;
    next();
    drive_idle();
  endtask

  task automatic test_cancel_addr();
    present(1'b1, 4'b0, 32'h4000, 32'h0);
    next();
    data_addr_ok = 1'b1; mem_cancel = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mem_stall !== 1'b0) $display("FAIL ca_stall: got %b, exp 0", mem_stall);
    else n_pass++;
    next();
    data_addr_ok = 1'b0;
    present(1'b1, 4'b0, 32'h5000, 32'h0);
    @(negedge clk);
    n_chk++;
    if ({data_req, mem_stall, mem_done} !== 3'b010) $display("FAIL ca_drain1: got req=%b stall=%b done=%b, exp 0 1 0", data_req, mem_stall, mem_done);
    else n_pass++;
    next();
    @(negedge clk);
    n_chk++;
    if ({data_req, mem_stall} !== 2'b01) $display("FAIL ca_drain2: got req=%b stall=%b, exp 0 1", data_req, mem_stall);
    else n_pass++;
    data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
    next();
    data_data_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({data_req, mem_stall, mem_rdata} !== {1'b0, 1'b1, exp_rdata})
      $display("FAIL ca_idle: got req=%b stall=%b rdata=%h, exp 0 1 %h", data_req, mem_stall, mem_rdata, exp_rdata);
    else n_pass++;
    next();
    @(negedge clk);
    n_chk++;
    if ({data_req, data_addr} !== {1'b1, 32'h5000}) $display("FAIL ca_issue: got req=%b addr=%h, exp 1 00005000", data_req, data_addr);
    else n_pass++;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    next();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    exp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    n_chk++;
    if ({mem_done, mem_rdata} !== {1'b1, exp_rdata}) $display("FAIL ca_done: got done=%b rdata=%h, exp 1 %h", mem_done, mem_rdata, exp_rdata);
    else n_pass++;
    mem_allowout = 1'b1; mem_valid = 1'b0; mem_ren = 1'b0;
    next();
    drive_idle();
  endtask

  task automatic test_back_to_back();
    present(1'b1, 4'b0, 32'h6000, 32'h0);
    next();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h11111111;
    next();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    exp_rdata = 32'h11111111;
    @(negedge clk);
    n_chk++;
    if ({mem_done, mem_rdata} !== {1'b1, exp_rdata}) $display("FAIL b2b_done1: got done=%b rdata=%h, exp 1 %h", mem_done, mem_rdata, exp_rdata);
    else n_pass++;
    present(1'b1, 4'b0, 32'h6004, 32'h0);
    mem_allowout = 1'b1;
    next();
    mem_allowout = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({data_req, data_addr, mem_done} !== {1'b1, 32'h6004, 1'b0})
      $display("FAIL b2b_req2: got req=%b addr=%h done=%b, exp 1 00006004 0", data_req, data_addr, mem_done);
    else n_pass++;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h22222222;
    next();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    exp_rdata = 32'h22222222;
    @(negedge clk);
    n_chk++;
    if ({mem_done, mem_rdata} !== {1'b1, exp_rdata}) $display("FAIL b2b_done2: got done=%b rdata=%h, exp 1 %h", mem_done, mem_rdata, exp_rdata);
    else n_pass++;
    mem_allowout = 1'b1; mem_valid = 1'b0; mem_ren = 1'b0;
    next();
    drive_idle();
  endtask

  task automatic test_random();
    logic        ld;
    logic [3:0]  wen;
    logic [31:0] addr, wd, rd, ea;
    logic [1:0]  es;
    int          ad, dd, pc;
    for (int t = 0; t < 60; t++) begin
      ld   = 1'($urandom_range(0, 1));
      wen  = ld ? 4'b0 : 4'($urandom_range(1, 15));
      addr = $urandom; wd = $urandom; rd = $urandom;
      ad   = $urandom_range(0, 2);
      dd   = $urandom_range(0, 2);
      pc   = $countones(wen);
      es   = ld ? 2'd2 : (pc == 1) ? 2'd0 : (pc == 2) ? 2'd1 : 2'd2;
      ea   = (es == 2'd2) ? {addr[31:2], 2'b00} : addr;
      present(ld, wen, addr, wd);
      @(negedge clk);
      n_chk++;
      if ({mem_stall, data_req} !== 2'b10) $display("FAIL rnd%0d_idle: got stall=%b req=%b, exp 1 0", t, mem_stall, data_req);
      else n_pass++;
      next();
      for (int k = 0; k < ad; k++) begin
        @(negedge clk);
        n_chk++;
        if ({data_req, data_addr, mem_stall} !== {1'b1, ea, 1'b1})
          $display("FAIL rnd%0d_hold: got req=%b addr=%h stall=%b, exp 1 %h 1", t, data_req, data_addr, mem_stall, ea);
        else n_pass++;
        next();
      end
      data_addr_ok = 1'b1;
      if (dd == 0) begin
        data_data_ok = 1'b1; data_rdata = rd;
      end
      @(negedge clk);
      n_chk++;
      if ({data_req, data_wr, data_size, data_wstrb, data_addr} !== {1'b1, ~ld, es, wen, ea})
        $display("FAIL rnd%0d_bus: got req=%b wr=%b size=%0d strb=%b addr=%h, exp 1 %b %0d %b %h",
                 t, data_req, data_wr, data_size, data_wstrb, data_addr, ~ld, es, wen, ea);
      else n_pass++;
      if (!ld) begin
        n_chk++;
        if (data_wdata !== wd) $display("FAIL rnd%0d_wdata: got %h, exp %h", t, data_wdata, wd);
        else n_pass++;
      end
      next();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (dd > 0) begin
        for (int k = 1; k < dd; k++) begin
          @(negedge clk);
          n_chk++;
          if ({data_req, mem_stall, mem_done} !== 3'b010)
            $display("FAIL rnd%0d_wait: got req=%b stall=%b done=%b, exp 0 1 0", t, data_req, mem_stall, mem_done);
          else n_pass++;
          next();
        end
        data_data_ok = 1'b1; data_rdata = rd;
        next();
        data_data_ok = 1'b0; data_rdata = $urandom;
      end
      if (ld) exp_rdata = rd;
      @(negedge clk);
      n_chk++;
      if ({mem_done, mem_stall, mem_rdata} !== {1'b1, 1'b0, exp_rdata})
        $display("FAIL rnd%0d_done: got done=%b stall=%b rdata=%h, exp 1 0 %h", t, mem_done, mem_stall, mem_rdata, exp_rdata);
      else n_pass++;
      mem_allowout = 1'b1; mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 4'b0;
      next();
      drive_idle();
    end
  endtask

  task automatic test_reset_mid();
    present(1'b1, 4'b0, 32'h7000, 32'h0);
    next();
    data_addr_ok = 1'b1;
    next();
    data_addr_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({data_req, mem_stall, data_addr} !== {1'b0, 1'b1, 32'h7000})
      $display("FAIL rm_wait: got req=%b stall=%b addr=%h, exp 0 1 00007000", data_req, mem_stall, data_addr);
    else n_pass++;
    #1;
    resetn = 1'b0;
    #1;
    exp_rdata = 32'h0;
    n_chk++;
    if ({data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata} !== 72'h0)
      $display("FAIL rm_bus: got req=%b wr=%b size=%0d strb=%b addr=%h wdata=%h, exp all zero",
               data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata);
    else n_pass++;
    n_chk++;
    if ({mem_stall, mem_done, mem_rdata} !== {1'b0, 1'b0, exp_rdata})
      $display("FAIL rm_mem: got stall=%b done=%b rdata=%h, exp 0 0 %h", mem_stall, mem_done, mem_rdata, exp_rdata);
    else n_pass++;
    drive_idle();
    next();
    resetn = 1'b1;
    next();
    @(negedge clk);
    n_chk++;
    if ({data_req, mem_done} !== 2'b00) $display("FAIL rm_after: got req=%b done=%b, exp 0 0", data_req, mem_done);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_word();
    test_store();
    test_cancel_wait();
    test_cancel_addr();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
